// File: rtl/fp_mul_operand_queue.sv
// Operand-pair FIFO ahead of the single-precision multiplier.
// Classifies each operand on entry and presents the head pair first-word-fall-through.
module fp_mul_operand_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_a,
    output logic [31:0]   out_b,
    output logic [2:0]    out_cls_a,
    output logic [2:0]    out_cls_b,
    output logic          out_sign,
    output logic          out_special,
    output logic [AW:0]   count,
    output logic          drop_sticky
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [2:0]  CLS_ZERO   = 3'd0;
    localparam logic [2:0]  CLS_DENORM = 3'd1;
    localparam logic [2:0]  CLS_NORMAL = 3'd2;
    localparam logic [2:0]  CLS_INF    = 3'd3;
    localparam logic [2:0]  CLS_NAN    = 3'd4;

    function automatic logic [2:0] classify(input logic [31:0] x);
        logic frac_nz;
        frac_nz = (x[22:0] != 23'd0);
        if (x[30:23] == 8'd0) begin
            classify = frac_nz ? CLS_DENORM : CLS_ZERO;
        end else if (x[30:23] == 8'hff) begin
            classify = frac_nz ? CLS_NAN : CLS_INF;
        end else begin
            classify = CLS_NORMAL;
        end
    endfunction

    logic [31:0]   a_mem   [DEPTH];
    logic [31:0]   b_mem   [DEPTH];
    logic [2:0]    cls_a_mem [DEPTH];
    logic [2:0]    cls_b_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          drop_q;
    logic          wr_en, rd_en;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            // A producer ignoring backpressure is recorded even during a flush.
            if (in_valid && !in_ready) begin
                drop_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (wr_en && !rd_en) begin
                    count_q <= count_q + 1'b1;
                end else if (rd_en && !wr_en) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            a_mem[wr_ptr_q]     <= in_a;
            b_mem[wr_ptr_q]     <= in_b;
            cls_a_mem[wr_ptr_q] <= classify(in_a);
            cls_b_mem[wr_ptr_q] <= classify(in_b);
        end
    end

    // Storage is not reset, so the head is masked to zero while the queue is empty.
    always_comb begin
        out_a     = '0;
        out_b     = '0;
        out_cls_a = CLS_ZERO;
        out_cls_b = CLS_ZERO;
        if (out_valid) begin
            out_a     = a_mem[rd_ptr_q];
            out_b     = b_mem[rd_ptr_q];
            out_cls_a = cls_a_mem[rd_ptr_q];
            out_cls_b = cls_b_mem[rd_ptr_q];
        end
    end

    assign out_sign    = out_a[31] ^ out_b[31];
    assign out_special = out_valid && ((out_cls_a != CLS_NORMAL) || (out_cls_b != CLS_NORMAL));
    assign count       = count_q;
    assign drop_sticky = drop_q;

endmodule

// File: tb/tb_fp_mul_operand_queue.sv
// Directed plus randomized bench for fp_mul_operand_queue against a queue-based model.
module tb_fp_mul_operand_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [31:0]   in_a, in_b;
    logic          in_ready, out_valid, out_sign, out_special, drop_sticky;
    logic [31:0]   out_a, out_b;
    logic [2:0]    out_cls_a, out_cls_b;
    logic [AW:0]   count;

    fp_mul_operand_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_cls_a(out_cls_a), .out_cls_b(out_cls_b), .out_sign(out_sign),
        .out_special(out_special), .count(count), .drop_sticky(drop_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t q[$];
    bit    m_drop;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic logic [2:0] ref_cls(input logic [31:0] x);
        int unsigned e;
        bit          nz;
        e  = x[30:23];
        nz = (x[22:0] != 0);
        if (e == 255) return nz ? 3'd4 : 3'd3;
        if (e == 0)   return nz ? 3'd1 : 3'd0;
        return 3'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] ca, cb;
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("drop_sticky", 32'(drop_sticky), 32'(m_drop));
        if (q.size() != 0) begin
            ca = ref_cls(q[0].a);
            cb = ref_cls(q[0].b);
            chk("out_a", out_a, q[0].a);
            chk("out_b", out_b, q[0].b);
            chk("out_cls_a", 32'(out_cls_a), 32'(ca));
            chk("out_cls_b", 32'(out_cls_b), 32'(cb));
            chk("out_sign", 32'(out_sign), 32'(q[0].a[31] != q[0].b[31]));
            chk("out_special", 32'(out_special), 32'(ca != 3'd2 || cb != 3'd2));
        end
    endtask

    // One clock: update the model from the inputs held across the edge, then compare.
    task automatic cycle();
        bit do_w, do_r;
        @(posedge clk);
        do_w = in_valid && (q.size() != DEPTH);
        do_r = out_ready && (q.size() != 0);
        if (rst) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            if (in_valid && q.size() == DEPTH) m_drop = 1'b1;
            if (flush) begin
                q.delete();
            end else begin
                if (do_r) void'(q.pop_front());
                if (do_w) q.push_back('{a: in_a, b: in_b});
            end
        end
        #1;
        check_all();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:0] = '0;
            1: x[30:23] = 8'h00;
            2: x[30:23] = 8'hff;
            3: x[30:0] = 31'h7f800000;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        m_drop = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_a", out_a, 32'h0);
        chk("rst_out_b", out_b, 32'h0);
        chk("rst_cls", {26'd0, out_cls_a, out_cls_b}, 32'h0);

        // Single pass
        push(32'h3FC00000, 32'h40000000);
        chk("sp_cls", {26'd0, out_cls_a, out_cls_b}, {26'd0, 3'd2, 3'd2});
        chk("sp_sign_special", {30'd0, out_sign, out_special}, 32'h0);
        chk("sp_count", 32'(count), 32'd1);
        pop();
        chk("sp_empty", {30'd0, out_valid, 1'b0}, 32'h0);

        // Classification
        push(32'h00000000, 32'h80000001);
        push(32'h7F800000, 32'hFF800001);
        push(32'hBF800000, 32'h7FC00000);
        chk("cl0_cls", {26'd0, out_cls_a, out_cls_b}, {26'd0, 3'd0, 3'd1});
        chk("cl0_ss", {30'd0, out_sign, out_special}, 32'h3);
        pop();
        chk("cl1_cls", {26'd0, out_cls_a, out_cls_b}, {26'd0, 3'd3, 3'd4});
        chk("cl1_sign", 32'(out_sign), 32'h1);
        pop();
        chk("cl2_cls", {26'd0, out_cls_a, out_cls_b}, {26'd0, 3'd2, 3'd4});
        chk("cl2_sign", 32'(out_sign), 32'h1);
        pop();

        // Full and backpressure: fifth write is refused
        for (int i = 0; i < 5; i++) push(32'h1000 + i, 32'h2000 + i);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_drop", 32'(drop_sticky), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_a, 32'h1000 + i);
            pop();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Concurrent read/write across pointer wrap
        push(32'h3000, 32'h4000);
        push(32'h3001, 32'h4001);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            in_a = 32'h3000 + i;
            in_b = 32'h4000 + i;
            cycle();
            chk("cc_count", 32'(count), 32'd2);
            chk("cc_head", out_a, 32'h3000 + i - 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        pop();
        pop();

        // Full with simultaneous read: read happens, write does not
        for (int i = 0; i < 4; i++) push(32'h5000 + i, 32'h6000 + i);
        in_valid = 1'b1; in_a = 32'h5004; in_b = 32'h6004; out_ready = 1'b1;
        cycle();
        chk("fr_count", 32'(count), 32'd3);
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk("fr_accept", 32'(count), 32'd4);

        // Flush from count=3, then reset
        pop();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_drop", 32'(drop_sticky), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rs_drop", 32'(drop_sticky), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            in_a      = rand_op();
            in_b      = rand_op();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
